fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage upstream of the memory port: drives mem_addr/mem_rw as a read-only master and captures mem_rdata.
- Buffers fetched words in a small FIFO and hands them to decode over a valid/ready handshake.
- Supports a single-cycle redirect from execute for branches and jumps.
- Never writes memory.

Parameters:
- RESET_PC, 32'h0000_0000, byte address of the first fetch after reset.
- DEPTH, 4, instruction FIFO entries (power of two, 2..16).

Ports:
- clk  input  1  clock, all logic on rising edge
- nreset  input  1  synchronous active-low reset
- fetch_en  input  1  enables issue of new fetch requests
- mem_req  output  1  read request valid this cycle
- mem_gnt  input  1  memory accepts request this cycle
- mem_addr  output  32  byte address of request, bits[1:0] always 0
- mem_rw  output  1  constant 0 (read); 1 = write is never driven
- mem_wdata  output  32  constant 0
- mem_rdata  input  32  read data, valid exactly 1 cycle after the granted request
- redirect  input  1  flush and restart fetch at redirect_pc
- redirect_pc  input  32  new fetch address; bits[1:0] ignored (forced 0)
- instr_valid  output  1  FIFO head valid
- instr_ready  input  1  decode accepts head
- instr_data  output  32  FIFO head instruction word
- instr_pc  output  32  byte address of instr_data

Behaviour:
- One clock, clk. Reset is synchronous, active-low on nreset. Sampled on the rising edge; no asynchronous terms.
- Reset values: pc=RESET_PC, state=S_IDLE, FIFO empty, inflight=0, drop=0, mem_req=0, mem_addr=RESET_PC, mem_rw=0, mem_wdata=0, instr_valid=0, instr_data=0, instr_pc=0.
- FSM S_IDLE:
  - mem_req=0.
  - -> S_RUN when fetch_en=1.
- FSM S_RUN:
  - mem_req = fetch_en && (count + inflight < DEPTH) && !redirect.
  - -> S_IDLE when fetch_en=0; any in-flight response still lands in the FIFO.
- Issue rules:
  - mem_addr = pc (combinational from the pc register).
  - On mem_req && mem_gnt: pc <= pc + 4 (wraps 32'hFFFF_FFFC -> 0), inflight <= 1, req_pc <= pc. Otherwise inflight <= 0.
  - Back-to-back issue every cycle is legal. Sustained throughput is 1 word/cycle when the FIFO drains at 1/cycle.
- Response: in the cycle after a grant with drop=0, push {req_pc, mem_rdata} into the FIFO. Credit accounting guarantees no overflow; the bench asserts push on full never occurs.
- Decode handshake:
  - instr_valid = !empty.
  - Pop on instr_valid && instr_ready.
  - Head outputs are stable while valid && !ready.
  - When empty, instr_data/instr_pc hold their last values.
- Simultaneous push and pop: count unchanged. Push to empty FIFO: visible next cycle (fetch-to-decode latency = 2 cycles from grant).
- Redirect (cycle R):
  - FIFO cleared at R's edge and pc <= {redirect_pc[31:2],2'b00}.
  - If a response is due in R+1 (grant in R), drop <= 1 and that response is discarded.
  - mem_req is forced 0 in R, so no grant can occur in R.
  - A pop coinciding with redirect is ignored (flush wins).
  - Fetch resumes in R+1 if fetch_en=1.
- Redirect in S_IDLE: pc updated, FIFO cleared, state unchanged.
- Reset mid-operation: all state returns to reset values at that edge. A response arriving the next cycle is ignored (inflight cleared).

Decomposition:
- Shared package fetch_pkg:
  - typedef fetch_entry_t {logic[31:0] pc; logic[31:0] instr;}
  - enum fetch_state_e {S_IDLE, S_RUN}
  - localparam INSTR_BYTES=4, MEM_READ=1'b0.
- One sub-module fetch_fifo (parameterised DEPTH, fetch_entry_t payload):
  - synchronous clear
  - push/pop, count output
  - same clk/nreset convention

Test Plan:
- Reset then fetch_en=1, mem_gnt=1 always, instr_ready=1 -> mem_addr 0,4,8,C on consecutive cycles; instr_pc 0,4,8 out starting 2 cycles after first grant, one per cycle.
- instr_ready=0, DEPTH=4, gnt=1 -> exactly 4 grants then mem_req=0; count=4; raise ready -> requests resume the cycle after the first pop.
- Redirect to 32'h0000_0103 in the cycle after a grant to 0x10 -> response for 0x10 discarded; next mem_addr=0x100; first instr_pc out=0x100; no stale entry visible.
- mem_gnt alternating 0/1 -> mem_addr holds until granted; instr_pc sequence contiguous, no duplicates or gaps.
- RESET_PC=32'hFFFF_FFF8 -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
- nreset low for one cycle mid-stream with FIFO holding 3 entries -> instr_valid=0 next cycle, mem_addr=RESET_PC, mem_rw=0 throughout.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned INSTR_BYTES = 4;
  localparam logic        MEM_READ    = 1'b0;
  // Wide enough for an occupancy count of up to 16 entries.
  localparam int unsigned CNT_W       = 5;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundles for the fetch stage: the memory read port and the decode hand-off.
interface fetch_mem_if;
  logic        mem_req;
  logic        mem_gnt;
  logic [31:0] mem_addr;
  logic        mem_rw;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (output mem_req, mem_addr, mem_rw, mem_wdata,
                  input  mem_gnt, mem_rdata);
  modport slave  (input  mem_req, mem_addr, mem_rw, mem_wdata,
                  output mem_gnt, mem_rdata);
endinterface

interface fetch_instr_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;

  modport master (output instr_valid, instr_data, instr_pc,
                  input  instr_ready);
  modport slave  (input  instr_valid, instr_data, instr_pc,
                  output instr_ready);
endinterface

// File: rtl/fetch_fifo.sv
// Instruction buffer: power-of-two ring of {pc, instr} entries with sync clear.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             clear,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  output fetch_entry_t     head,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (count != CNT_W'(DEPTH));
  assign head    = mem[rd_ptr];

  // Entry storage; needs no reset since occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; clear has priority over any push/pop.
  always_ff @(posedge clk) begin
    if (!nreset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: read-only memory master feeding a small FIFO to decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 fetch_en,
  input  logic                 redirect,
  input  logic [31:0]          redirect_pc,
  fetch_mem_if.master          mem,
  fetch_instr_if.master        instr
);

  fetch_state_e     state;
  fetch_state_e     state_nxt;
  logic [31:0]      pc;
  logic [31:0]      req_pc;
  logic             inflight;
  logic             drop;
  logic             grant;
  logic             push;
  logic             empty;
  logic [CNT_W-1:0] count;
  fetch_entry_t     head;
  fetch_entry_t     hold;
  fetch_entry_t     push_data;
  logic             unused_bits;

  assign unused_bits   = ^redirect_pc[1:0];
  assign mem.mem_addr  = pc;
  assign mem.mem_rw    = MEM_READ;
  assign mem.mem_wdata = '0;
  assign grant         = mem.mem_req && mem.mem_gnt;
  assign push          = inflight && !drop;
  assign push_data     = '{pc: req_pc, instr: mem.mem_rdata};

  // State register.
  always_ff @(posedge clk) begin
    if (!nreset) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next state and request; credits count in-flight responses so the FIFO never overflows.
  always_comb begin
    state_nxt   = state;
    mem.mem_req = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (fetch_en) state_nxt = S_RUN;
      end
      S_RUN: begin
        mem.mem_req = fetch_en && !redirect &&
                      ((32'(count) + 32'(inflight)) < DEPTH);
        if (!fetch_en) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // PC and response tracking; redirect overrides sequential advance.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      pc       <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
      drop     <= 1'b0;
    end else begin
      inflight <= grant;
      drop     <= grant && redirect;
      if (grant) req_pc <= pc;
      if (redirect)   pc <= {redirect_pc[31:2], 2'b00};
      else if (grant) pc <= pc + 32'(INSTR_BYTES);
    end
  end

  // Last displayed head, shown while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!nreset)     hold <= '0;
    else if (!empty) hold <= head;
  end

  assign instr.instr_valid = !empty;
  assign instr.instr_data  = empty ? hold.instr : head.instr;
  assign instr.instr_pc    = empty ? hold.pc    : head.pc;

  // Redirect flushes the buffer, which also discards a response landing that cycle.
  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .nreset    (nreset),
    .clear     (redirect),
    .push      (push),
    .push_data (push_data),
    .pop       (instr.instr_ready),
    .head      (head),
    .empty     (empty),
    .count     (count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a memory model and pc scoreboard.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int unsigned D    = 4;
  localparam logic [31:0] RPC1 = 32'h0000_0000;
  localparam logic [31:0] RPC2 = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        nreset, fetch_en, redirect;
  logic [31:0] redirect_pc;
  logic        nreset2, fetch_en2, redirect2;
  logic [31:0] redirect_pc2;

  fetch_mem_if   mif ();
  fetch_instr_if iif ();
  fetch_mem_if   mif2 ();
  fetch_instr_if iif2 ();

  // 10 time-unit clock period.
  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC1), .DEPTH(D)) dut (
    .clk(clk), .nreset(nreset), .fetch_en(fetch_en), .redirect(redirect),
    .redirect_pc(redirect_pc), .mem(mif), .instr(iif)
  );

  fetch_unit #(.RESET_PC(RPC2), .DEPTH(D)) dut_wrap (
    .clk(clk), .nreset(nreset2), .fetch_en(fetch_en2), .redirect(redirect2),
    .redirect_pc(redirect_pc2), .mem(mif2), .instr(iif2)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_pc = RPC1;
  logic [31:0] last_pc = '0;
  logic [31:0] last_data = '0;
  logic [31:0] pend_addr = '0;
  logic        pend_v = 1'b0;
  logic        s_req, s_valid, s_grant, s_pop;
  logic [31:0] s_addr, s_pc, s_data;
  logic        s2_req, s2_valid;
  logic [31:0] s2_addr, s2_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, expv);
    end
  endtask

  // One clock of the main DUT: sample after inputs settle, check, update model, advance.
  task automatic cycle();
    #1;
    s_req   = mif.mem_req;
    s_addr  = mif.mem_addr;
    s_valid = iif.instr_valid;
    s_pc    = iif.instr_pc;
    s_data  = iif.instr_data;
    chk("mem_rw", 32'(mif.mem_rw), 32'(MEM_READ));
    chk("mem_wdata", mif.mem_wdata, 32'h0);
    chk("instr_valid", 32'(s_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("head_pc", s_pc, exp_q[0]);
      chk("head_data", s_data, mem_word(exp_q[0]));
      last_pc   = exp_q[0];
      last_data = mem_word(exp_q[0]);
    end else begin
      chk("hold_pc", s_pc, last_pc);
      chk("hold_data", s_data, last_data);
    end
    if (s_req) chk("mem_addr", s_addr, model_pc);
    s_grant = s_req && mif.mem_gnt;
    s_pop   = nreset && !redirect && s_valid && iif.instr_ready;
    if (s_pop && exp_q.size() != 0) void'(exp_q.pop_front());
    if (pend_v && nreset && !redirect) begin
      chk("no_push_on_full", 32'(exp_q.size() < D), 32'd1);
      exp_q.push_back(pend_addr);
    end
    if (!nreset) begin
      exp_q.delete();
      model_pc  = RPC1;
      last_pc   = '0;
      last_data = '0;
    end else if (redirect) begin
      exp_q.delete();
      model_pc = {redirect_pc[31:2], 2'b00};
    end else if (s_grant) begin
      model_pc = model_pc + 32'd4;
    end
    pend_v    = s_grant && nreset && !redirect;
    pend_addr = s_addr;
    @(posedge clk);
    #1;
    mif.mem_rdata = pend_v ? mem_word(pend_addr) : (32'hBAD0_0000 | 32'(cyc));
    cyc++;
    @(negedge clk);
  endtask

  // One clock for the wrap-around instance.
  task automatic cycle2();
    #1;
    s2_req   = mif2.mem_req;
    s2_addr  = mif2.mem_addr;
    s2_valid = iif2.instr_valid;
    s2_pc    = iif2.instr_pc;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int          n;
    logic        found;
    logic        have_prev, prev_stall;
    logic [31:0] prev_pc, prev_addr;

    nreset = 1'b0; fetch_en = 1'b0; redirect = 1'b0; redirect_pc = '0;
    mif.mem_gnt = 1'b0; mif.mem_rdata = '0; iif.instr_ready = 1'b0;
    nreset2 = 1'b0; fetch_en2 = 1'b0; redirect2 = 1'b0; redirect_pc2 = '0;
    mif2.mem_gnt = 1'b0; mif2.mem_rdata = 32'h5555_AAAA; iif2.instr_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values
    cycle();
    chk("rst_mem_req", 32'(s_req), 32'd0);
    chk("rst_mem_addr", s_addr, RPC1);
    chk("rst_instr_valid", 32'(s_valid), 32'd0);
    chk("rst_instr_pc", s_pc, 32'h0);
    chk("rst_instr_data", s_data, 32'h0);

    // Streaming fetch with full throughput
    nreset = 1'b1;
    cycle();
    fetch_en = 1'b1; mif.mem_gnt = 1'b1; iif.instr_ready = 1'b1;
    cycle(); chk("p1_idle_no_req", 32'(s_req), 32'd0);
    cycle(); chk("p1_req", 32'(s_req), 32'd1); chk("p1_addr0", s_addr, 32'h0);
    cycle(); chk("p1_addr4", s_addr, 32'h4); chk("p1_lat_not_yet", 32'(s_valid), 32'd0);
    cycle(); chk("p1_addr8", s_addr, 32'h8); chk("p1_lat2_valid", 32'(s_valid), 32'd1);
             chk("p1_pc0", s_pc, 32'h0);
    cycle(); chk("p1_addrC", s_addr, 32'hC); chk("p1_pc4", s_pc, 32'h4);
    cycle(); chk("p1_pc8", s_pc, 32'h8);
    fetch_en = 1'b0;
    repeat (5) cycle();

    // Backpressure fills exactly DEPTH entries
    iif.instr_ready = 1'b0; fetch_en = 1'b1;
    n = 0;
    repeat (10) begin
      cycle();
      if (s_grant) n++;
    end
    chk("bp_grants", 32'(n), 32'(D));
    chk("bp_req_low", 32'(s_req), 32'd0);
    iif.instr_ready = 1'b1;
    cycle(); chk("bp_pop_cycle_req", 32'(s_req), 32'd0); chk("bp_valid", 32'(s_valid), 32'd1);
    cycle(); chk("bp_resume_req", 32'(s_req), 32'd1);
    fetch_en = 1'b0;
    repeat (8) cycle();

    // Redirect discards the response of the preceding grant
    fetch_en = 1'b1;
    cycle();
    redirect = 1'b1; redirect_pc = 32'h0000_0010;
    cycle(); chk("rd_req_forced0", 32'(s_req), 32'd0);
    redirect = 1'b0;
    cycle(); chk("rd_addr10", s_addr, 32'h10); chk("rd_req10", 32'(s_req), 32'd1);
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    cycle(); chk("rd2_req_forced0", 32'(s_req), 32'd0);
    redirect = 1'b0;
    cycle(); chk("rd_addr100", s_addr, 32'h100); chk("rd_no_stale", 32'(s_valid), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (s_valid && !found) begin
        found = 1'b1;
        chk("rd_first_pc", s_pc, 32'h100);
      end
    end
    chk("rd_found_timeout", 32'(found), 32'd1);

    // Alternating grant: address holds while stalled, popped pcs contiguous
    have_prev = 1'b0; prev_stall = 1'b0; prev_pc = '0; prev_addr = '0;
    for (int i = 0; i < 20; i++) begin
      mif.mem_gnt = (i % 2) == 1;
      cycle();
      if (prev_stall) chk("alt_addr_hold", s_addr, prev_addr);
      prev_stall = s_req && !s_grant;
      prev_addr  = s_addr;
      if (s_pop) begin
        if (have_prev) chk("alt_contig", s_pc, prev_pc + 32'd4);
        prev_pc   = s_pc;
        have_prev = 1'b1;
      end
    end
    mif.mem_gnt = 1'b1;
    fetch_en = 1'b0;
    repeat (8) cycle();

    // Reset mid-stream with three buffered entries
    iif.instr_ready = 1'b0; fetch_en = 1'b1;
    cycle();
    repeat (3) cycle();
    fetch_en = 1'b0;
    cycle();
    cycle(); chk("mr_three_buffered", 32'(exp_q.size()), 32'd3);
             chk("mr_valid_before", 32'(s_valid), 32'd1);
    nreset = 1'b0;
    cycle();
    nreset = 1'b1;
    cycle(); chk("mr_valid0", 32'(s_valid), 32'd0); chk("mr_addr", s_addr, RPC1);
             chk("mr_pc0", s_pc, 32'h0);

    // Address wrap from a high reset pc
    nreset2 = 1'b1; fetch_en2 = 1'b1; mif2.mem_gnt = 1'b1; iif2.instr_ready = 1'b1;
    cycle2(); chk("w_idle_req", 32'(s2_req), 32'd0); chk("w_idle_addr", s2_addr, RPC2);
    cycle2(); chk("w_req", 32'(s2_req), 32'd1); chk("w_addr0", s2_addr, 32'hFFFF_FFF8);
    cycle2(); chk("w_addr1", s2_addr, 32'hFFFF_FFFC);
    cycle2(); chk("w_addr2", s2_addr, 32'h0000_0000);
              chk("w_first_valid", 32'(s2_valid), 32'd1); chk("w_first_pc", s2_pc, 32'hFFFF_FFF8);
    cycle2(); chk("w_second_pc", s2_pc, 32'hFFFF_FFFC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
